multicycle_controller: RTL and testbench

//  Parametrised multicycle RV32I(+M) control unit: main FSM, ALU/imm/branch decode, PC-write logic.

---
 rtl/multicycle_controller.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Multicycle RV32I(+M) control FSM with memory wait, MDU handshake,
//            MDU watchdog and illegal-instruction trap.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module multicycle_controller #(
    parameter int ENABLE_WAIT     = 1,
    parameter int ENABLE_MDU      = 1,
    parameter int MDU_TIMEOUT     = 64,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       cout,
    input  logic       overflow,
    input  logic       sign,
    input  logic       mem_ready,
    input  logic       mdu_done,
    output logic [2:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [3:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       memread,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       illegal
);

    typedef enum logic [4:0] {
        c_fetch    = 5'd0,  c_decode  = 5'd1,  c_memadr  = 5'd2,  c_memread = 5'd3,
        c_memwb    = 5'd4,  c_memwrite = 5'd5, c_execr   = 5'd6,  c_execi   = 5'd7,
        c_aluwb    = 5'd8,  c_branch  = 5'd9,  c_jal     = 5'd10, c_jalr    = 5'd11,
        c_lui      = 5'd12, c_auipc   = 5'd13, c_mdustart = 5'd14, c_mduwait = 5'd15,
        c_mduwb    = 5'd16, c_trap    = 5'd17
    } state_t;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_and  = 4'd2;
    localparam logic [3:0] c_alu_or   = 4'd3;
    localparam logic [3:0] c_alu_xor  = 4'd4;
    localparam logic [3:0] c_alu_slt  = 4'd5;
    localparam logic [3:0] c_alu_sltu = 4'd6;
    localparam logic [3:0] c_alu_sll  = 4'd7;
    localparam logic [3:0] c_alu_srl  = 4'd8;
    localparam logic [3:0] c_alu_sra  = 4'd9;

    localparam int                c_wd_w    = $clog2(MDU_TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(MDU_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_illegal;
    logic [c_wd_w-1:0]   r_wdog;
    logic                w_set_illegal;
    logic                w_dec_illegal;
    logic                w_mr;
    logic                w_take;
    logic [3:0]          w_alu_dec;

    assign w_mr    = (ENABLE_WAIT != 0) ? mem_ready : 1'b1;
    assign mdu_op  = funct3;
    assign illegal = r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_fetch;
            r_illegal <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            r_wdog <= (r_state == c_mduwait && w_next == c_mduwait) ? r_wdog + 1'b1 : '0;
        end
    end

    // op[5] separates R-type from OP-IMM: only R-type turns funct7[5] into sub.
    always_comb begin
        w_alu_dec = c_alu_add;
        case (funct3)
            3'b000:  w_alu_dec = (op[5] && funct7[5]) ? c_alu_sub : c_alu_add;
            3'b001:  w_alu_dec = c_alu_sll;
            3'b010:  w_alu_dec = c_alu_slt;
            3'b011:  w_alu_dec = c_alu_sltu;
            3'b100:  w_alu_dec = c_alu_xor;
            3'b101:  w_alu_dec = funct7[5] ? c_alu_sra : c_alu_srl;
            3'b110:  w_alu_dec = c_alu_or;
            default: w_alu_dec = c_alu_and;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (funct3)
            3'b000:  w_take = zero;
            3'b001:  w_take = ~zero;
            3'b100:  w_take = (sign != overflow);
            3'b101:  w_take = (sign == overflow);
            3'b110:  w_take = ~cout;
            3'b111:  w_take = cout;
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_dec_illegal = 1'b0;
        alusrca       = 2'b00;
        alusrcb       = 2'b00;
        resultsrc     = 2'b00;
        adrsrc        = 1'b0;
        alucontrol    = c_alu_add;
        irwrite       = 1'b0;
        pcwrite       = 1'b0;
        regwrite      = 1'b0;
        memwrite      = 1'b0;
        memread       = 1'b0;
        mdu_start     = 1'b0;

        case (op)
            7'b0100011:             immsrc = 3'b001;
            7'b1100011:             immsrc = 3'b010;
            7'b1101111:             immsrc = 3'b011;
            7'b0110111, 7'b0010111: immsrc = 3'b100;
            default:                immsrc = 3'b000;
        endcase

        case (r_state)
            c_fetch: begin
                memread   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = w_mr;
                pcwrite   = w_mr;
                if (w_mr) w_next = c_decode;
            end
            c_decode: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: w_next = c_memadr;
                    7'b0110011: begin
                        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) w_next = c_execr;
                        else if (ENABLE_MDU != 0 && funct7 == 7'b0000001) w_next = c_mdustart;
                        else w_dec_illegal = 1'b1;
                    end
                    7'b0010011: w_next = c_execi;
                    7'b1100011: begin
                        if (funct3[2:1] == 2'b01) w_dec_illegal = 1'b1;
                        else w_next = c_branch;
                    end
                    7'b1101111: w_next = c_jal;
                    7'b1100111: w_next = c_jalr;
                    7'b0110111: w_next = c_lui;
                    7'b0010111: w_next = c_auipc;
                    default:    w_dec_illegal = 1'b1;
                endcase
                if (w_dec_illegal) begin
                    w_next        = (TRAP_ON_ILLEGAL != 0) ? c_trap : c_fetch;
                    w_set_illegal = (TRAP_ON_ILLEGAL != 0);
                end
            end
            c_memadr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                w_next  = op[5] ? c_memwrite : c_memread;
            end
            c_memread: begin
                adrsrc  = 1'b1;
                memread = 1'b1;
                if (w_mr) w_next = c_memwb;
            end
            c_memwb: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                w_next    = c_fetch;
            end
            c_memwrite: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (w_mr) w_next = c_fetch;
            end
            c_execr: begin
                alusrca    = 2'b10;
                alucontrol = w_alu_dec;
                w_next     = c_aluwb;
            end
            c_execi: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                alucontrol = w_alu_dec;
                w_next     = c_aluwb;
            end
            c_aluwb: begin
                regwrite = 1'b1;
                w_next   = c_fetch;
            end
            c_branch: begin
                alusrca    = 2'b10;
                alucontrol = c_alu_sub;
                pcwrite    = w_take;
                w_next     = c_fetch;
            end
            // Target was computed in DECODE; this cycle forms OldPC+4 for the link write.
            c_jal: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                w_next  = c_aluwb;
            end
            c_jalr: begin
                alusrca   = 2'b10;
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                pcwrite   = 1'b1;
                w_next    = c_aluwb;
            end
            c_lui: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                w_next  = c_aluwb;
            end
            c_auipc: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                w_next  = c_aluwb;
            end
            c_mdustart: begin
                mdu_start = 1'b1;
                w_next    = c_mduwait;
            end
            c_mduwait: begin
                if (mdu_done) begin
                    w_next = c_mduwb;
                end else if (r_wdog == c_wd_last) begin
                    w_next        = c_trap;
                    w_set_illegal = 1'b1;
                end
            end
            c_mduwb: begin
                resultsrc = 2'b11;
                regwrite  = 1'b1;
                w_next    = c_fetch;
            end
            c_trap:  w_next = c_trap;
            default: w_next = c_fetch;
        endcase

        if (reset) begin
            irwrite   = 1'b0;
            pcwrite   = 1'b0;
            regwrite  = 1'b0;
            memwrite  = 1'b0;
            memread   = 1'b0;
            mdu_start = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized scoreboard bench for multicycle_controller (two configs).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic [3:0] alu;
        logic [2:0] mdu_op;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       mdu_start;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t  e;
        ctl_t  m;
        string nm;
    } exp_t;

    // Config 0: waits, MDU, short watchdog, trapping. Config 1: no wait, no MDU, NOP on illegal.
    localparam int EW[2] = '{1, 0};
    localparam int EM[2] = '{1, 0};
    localparam int TO[2] = '{8, 64};
    localparam int TI[2] = '{1, 0};

    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5;
    localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_MDU = 9, C_ILL = 10;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       zero, cout, overflow, sign, mem_ready, mdu_done;
    ctl_t [1:0] act;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [2:0] immsrc, mdu_op;
        logic [1:0] alusrca, alusrcb, resultsrc;
        logic [3:0] alucontrol;
        logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, memread, mdu_start, illegal;

        multicycle_controller #(
            .ENABLE_WAIT(EW[k]), .ENABLE_MDU(EM[k]), .MDU_TIMEOUT(TO[k]), .TRAP_ON_ILLEGAL(TI[k])
        ) dut (
            .clk(clk), .reset(rst[k]), .op(op), .funct3(funct3), .funct7(funct7),
            .zero(zero), .cout(cout), .overflow(overflow), .sign(sign),
            .mem_ready(mem_ready), .mdu_done(mdu_done),
            .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
            .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
            .regwrite(regwrite), .memwrite(memwrite), .memread(memread),
            .mdu_start(mdu_start), .mdu_op(mdu_op), .illegal(illegal)
        );

        assign act[k] = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol, mdu_op,
                         irwrite, pcwrite, regwrite, memwrite, memread, mdu_start, illegal};
    end

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic m_ill[2];
    logic ab;
    int   abort_cnt;

    // ---------------- monitor ----------------
    task automatic check_one(input ctl_t a, input exp_t x, input int k);
        n_chk++;
        if (((a ^ x.e) & x.m) != '0) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual=%h required=%h mask=%h", x.nm, k, a, x.e, x.m);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q0.size() > 0) begin x = q0.pop_front(); check_one(act[0], x, 0); end
        if (q1.size() > 0) begin x = q1.pop_front(); check_one(act[1], x, 1); end
    end

    // ---------------- reference model helpers ----------------
    function automatic ctl_t en_mask();
        ctl_t m = '0;
        m.irwrite = 1'b1; m.pcwrite = 1'b1; m.regwrite = 1'b1; m.memwrite = 1'b1;
        m.memread = 1'b1; m.mdu_start = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    function automatic ctl_t base(input int k);
        ctl_t e = '0;
        case (op)
            7'b0100011:             e.immsrc = 3'd1;
            7'b1100011:             e.immsrc = 3'd2;
            7'b1101111:             e.immsrc = 3'd3;
            7'b0110111, 7'b0010111: e.immsrc = 3'd4;
            default:                e.immsrc = 3'd0;
        endcase
        e.mdu_op  = funct3;
        e.illegal = m_ill[k];
        return e;
    endfunction

    function automatic int classify(input int k);
        case (op)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: begin
                if (funct7 == 7'h00 || funct7 == 7'h20) return C_R;
                if (funct7 == 7'h01 && EM[k] != 0) return C_MDU;
                return C_ILL;
            end
            7'b0010011: return C_I;
            7'b1100011: return (funct3 == 3'd2 || funct3 == 3'd3) ? C_ILL : C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_ref(input logic isr);
        case (funct3)
            3'd0:    return (isr && funct7[5]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return funct7[5] ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic bg();
        mem_ready = 1'($urandom_range(0, 1));
        mdu_done  = ($urandom_range(0, 3) == 0);
        zero      = 1'($urandom_range(0, 1));
        cout      = 1'($urandom_range(0, 1));
        overflow  = 1'($urandom_range(0, 1));
        sign      = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input int k, input ctl_t e, input ctl_t m, input string nm);
        exp_t x;
        x.e = e; x.m = m; x.nm = nm;
        if (k == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic rst_cycle(input int k, input string nm);
        ctl_t e = '0;
        rst[k]    = 1'b1;
        mem_ready = 1'b1;
        e.illegal = m_ill[k];
        push(k, e, en_mask(), nm);
        @(posedge clk); #1;
        rst[k]   = 1'b0;
        m_ill[k] = 1'b0;
        bg();
    endtask

    task automatic cyc(input int k, input ctl_t e, input string nm);
        if (ab) return;
        if (abort_cnt == 0) begin
            abort_cnt = -1;
            ab = 1'b1;
            rst_cycle(k, "abort_reset");
            return;
        end
        if (abort_cnt > 0) abort_cnt--;
        push(k, e, '1, nm);
        @(posedge clk); #1;
        bg();
    endtask

    task automatic aluwb(input int k);
        ctl_t e = base(k);
        e.regwrite = 1'b1;
        cyc(k, e, "aluwb");
    endtask

    task automatic trap(input int k);
        ctl_t e;
        if (!ab) m_ill[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = base(k);
            cyc(k, e, "trap_hold");
        end
        if (!ab) rst_cycle(k, "trap_reset");
    endtask

    task automatic gen_instr();
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        case ($urandom_range(0, 11))
            0:  begin op = 7'b0110011; funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            1:  begin op = 7'b0110011; funct7 = 7'h01; end
            2:  op = 7'b0010011;
            3:  op = 7'b0000011;
            4:  op = 7'b0100011;
            5:  op = 7'b1100011;
            6:  op = 7'b1101111;
            7:  op = 7'b1100111;
            8:  op = 7'b0110111;
            9:  op = 7'b0010111;
            10: op = 7'($urandom);
            default: op = 7'b0110011;
        endcase
    endtask

    task automatic run_instr(input int k);
        ctl_t        e;
        int          cls, d;
        logic        mr, take;
        logic [31:0] a, b, diff;
        ab = 1'b0;
        abort_cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
        gen_instr();
        cls = classify(k);

        for (int i = 0; i < 50; i++) begin
            if (i >= 5) mem_ready = 1'b1;
            mr = (EW[k] != 0) ? mem_ready : 1'b1;
            e = base(k);
            e.memread = 1'b1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
            e.irwrite = mr;   e.pcwrite = mr;
            cyc(k, e, "fetch");
            if (mr) break;
        end
        e = base(k); e.alusrca = 2'b01; e.alusrcb = 2'b01;
        cyc(k, e, "decode");

        case (cls)
            C_LOAD, C_STORE: begin
                e = base(k); e.alusrca = 2'b10; e.alusrcb = 2'b01;
                cyc(k, e, "memadr");
                for (int i = 0; i < 50; i++) begin
                    if (i >= 5) mem_ready = 1'b1;
                    mr = (EW[k] != 0) ? mem_ready : 1'b1;
                    e = base(k); e.adrsrc = 1'b1;
                    if (cls == C_LOAD) e.memread = 1'b1;
                    else               e.memwrite = 1'b1;
                    cyc(k, e, "memwait");
                    if (mr) break;
                end
                if (cls == C_LOAD) begin
                    e = base(k); e.resultsrc = 2'b01; e.regwrite = 1'b1;
                    cyc(k, e, "memwb");
                end
            end
            C_R, C_I: begin
                e = base(k); e.alusrca = 2'b10;
                e.alusrcb = (cls == C_I) ? 2'b01 : 2'b00;
                e.alu = alu_ref(cls == C_R);
                cyc(k, e, "exec");
                aluwb(k);
            end
            C_BR: begin
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                diff = a - b;
                zero = (a == b);
                cout = (a >= b);
                sign = diff[31];
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
                case (funct3)
                    3'd0:    take = (a == b);
                    3'd1:    take = (a != b);
                    3'd4:    take = ($signed(a) < $signed(b));
                    3'd5:    take = ($signed(a) >= $signed(b));
                    3'd6:    take = (a < b);
                    default: take = (a >= b);
                endcase
                e = base(k); e.alusrca = 2'b10; e.alu = 4'd1; e.pcwrite = take;
                cyc(k, e, "branch");
            end
            C_JAL: begin
                e = base(k); e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1;
                cyc(k, e, "jal");
                aluwb(k);
            end
            C_JALR: begin
                e = base(k); e.alusrca = 2'b10; e.alusrcb = 2'b01;
                e.resultsrc = 2'b10; e.pcwrite = 1'b1;
                cyc(k, e, "jalr");
                aluwb(k);
            end
            C_LUI, C_AUIPC: begin
                e = base(k);
                e.alusrca = (cls == C_LUI) ? 2'b10 : 2'b01;
                e.alusrcb = 2'b01;
                cyc(k, e, "upper");
                aluwb(k);
            end
            C_MDU: begin
                e = base(k); e.mdu_start = 1'b1;
                cyc(k, e, "mdustart");
                d = $urandom_range(1, TO[k] + 3);
                for (int i = 0; i < TO[k]; i++) begin
                    mdu_done = (i == d - 1);
                    e = base(k);
                    cyc(k, e, "mduwait");
                    if (i == d - 1) break;
                end
                if (d <= TO[k]) begin
                    e = base(k); e.resultsrc = 2'b11; e.regwrite = 1'b1;
                    cyc(k, e, "mduwb");
                end else begin
                    trap(k);
                end
            end
            default: begin
                if (TI[k] != 0) trap(k);
            end
        endcase
    endtask

    initial begin
        rst = 2'b11;
        op = '0; funct3 = '0; funct7 = '0;
        m_ill[0] = 1'b0; m_ill[1] = 1'b0;
        ab = 1'b0; abort_cnt = -1;
        bg();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            push(0, '0, en_mask(), "reset_hold");
            push(1, '0, en_mask(), "reset_hold");
            @(posedge clk); #1;
        end
        rst = 2'b10;
        for (int n = 0; n < 250; n++) run_instr(0);
        rst = 2'b01;
        for (int n = 0; n < 80; n++) run_instr(1);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
